// File: rtl/servo_ctrl_pkg.sv
// Shared types and constants for the servo frame scheduler.
package servo_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_STORE,
        S_COMMIT,
        S_DONE
    } sched_state_t;

    localparam int unsigned WORD_W = 9;
    localparam int unsigned POS_W  = 8;
    localparam logic [WORD_W-1:0] EOF_TOKEN = 9'd256;

    localparam int unsigned ERR_LEN     = 0;
    localparam int unsigned ERR_RANGE   = 1;
    localparam int unsigned ERR_TIMEOUT = 2;
    localparam int unsigned ERR_CSUM    = 3;

    // Words 0 and EOF never carry a position.
    function automatic logic is_reserved(input logic [WORD_W-1:0] w);
        return (w == '0) || (w == EOF_TOKEN);
    endfunction

endpackage

// File: rtl/servo_rd_watchdog.sv
// Loadable down-counter that flags a buffer read not answered within RD_TIMEOUT cycles.
module servo_rd_watchdog #(
    parameter int unsigned RD_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(RD_TIMEOUT);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the RD_TIMEOUT-th enabled cycle after a load.
    assign expired_o = en_i && (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/servo_frame_sched.sv
// Sequences one SPI frame into servo positions and commits them atomically.
// Optional trailing checksum word: define SERVO_FRAME_CHECKSUM_EN.
module servo_frame_sched
    import servo_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH     = 8,
    parameter logic [7:0]  MAX_POS    = 8'd250,
    parameter int unsigned RD_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_ready,
    input  logic [8:0]            frame_len,
    output logic                  rd_req,
    input  logic [8:0]            rd_data,
    input  logic                  rd_valid,
    output logic                  frame_done,
    output logic [NUM_CH*8-1:0]   ch_pos,
    output logic [NUM_CH-1:0]     ch_update,
    output logic                  busy,
    output logic [3:0]            err
);

`ifdef SERVO_FRAME_CHECKSUM_EN
    localparam bit          CSUM_EN = 1'b1;
    localparam int unsigned MIN_LEN = 2;
    localparam int unsigned MAX_LEN = NUM_CH + 1;
`else
    localparam bit          CSUM_EN = 1'b0;
    localparam int unsigned MIN_LEN = 1;
    localparam int unsigned MAX_LEN = NUM_CH;
`endif

    localparam int unsigned IDX_W = $clog2(NUM_CH + 2);

    sched_state_t            state_q, state_d;
    logic [8:0]              len_q, len_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic [NUM_CH*8-1:0]     shadow_q, shadow_d;
    logic [NUM_CH*8-1:0]     pos_q, pos_d;
    logic [NUM_CH-1:0]       mask_q, mask_d;
    logic [3:0]              err_q, err_d;
    logic [POS_W-1:0]        csum_q, csum_d;
    logic                    holdoff_q;
    logic                    wd_load, wd_en, wd_expired;
    logic                    len_bad, last_word;

    servo_rd_watchdog #(
        .RD_TIMEOUT(RD_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .load_i    (wd_load),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    assign len_bad   = (frame_len < 9'(MIN_LEN)) || (frame_len > 9'(MAX_LEN));
    assign last_word = ((9'(idx_q) + 9'd1) == len_q);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        word_d   = word_q;
        shadow_d = shadow_q;
        pos_d    = pos_q;
        mask_d   = mask_q;
        err_d    = err_q;
        csum_d   = csum_q;
        wd_load  = 1'b0;
        wd_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_ready && !holdoff_q) begin
                    len_d = frame_len;
                    if (len_bad) begin
                        err_d[ERR_LEN] = 1'b1;
                        state_d        = S_DONE;
                    end else begin
                        idx_d   = '0;
                        csum_d  = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                wd_load = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_en = 1'b1;
                if (rd_valid) begin
                    word_d  = rd_data;
                    state_d = S_STORE;
                end else if (wd_expired) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = S_DONE;
                end
            end
            S_STORE: begin
                if (CSUM_EN && last_word) begin
                    if (csum_q != word_q[7:0]) begin
                        err_d[ERR_CSUM] = 1'b1;
                        state_d         = S_DONE;
                    end else begin
                        state_d = S_COMMIT;
                    end
                end else begin
                    // Checksum covers raw words, including reserved and clamped ones.
                    csum_d = csum_q + word_q[7:0];
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            if (is_reserved(word_q)) begin
                                err_d[ERR_RANGE] = 1'b1;
                            end else if (word_q[7:0] > MAX_POS) begin
                                shadow_d[8*i +: 8] = MAX_POS;
                                mask_d[i]          = 1'b1;
                                err_d[ERR_RANGE]   = 1'b1;
                            end else begin
                                shadow_d[8*i +: 8] = word_q[7:0];
                                mask_d[i]          = 1'b1;
                            end
                        end
                    end
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = (!CSUM_EN && last_word) ? S_COMMIT : S_FETCH;
                end
            end
            S_COMMIT: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (mask_q[i]) begin
                        pos_d[8*i +: 8] = shadow_q[8*i +: 8];
                    end
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                mask_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!CSUM_EN) begin
            err_d[ERR_CSUM] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            shadow_q  <= '0;
            pos_q     <= '0;
            mask_q    <= '0;
            err_q     <= '0;
            csum_q    <= '0;
            holdoff_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            shadow_q  <= shadow_d;
            pos_q     <= pos_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
            csum_q    <= csum_d;
            // Give the buffer one cycle after DONE to drop frame_ready.
            holdoff_q <= (state_q == S_DONE);
        end
    end

    assign rd_req     = (state_q == S_FETCH);
    assign frame_done = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign ch_update  = (state_q == S_COMMIT) ? mask_q : '0;
    assign ch_pos     = pos_q;
    assign err        = err_q;

endmodule

// File: tb/tb_servo_frame_sched.sv
// Directed self-checking bench for servo_frame_sched (NUM_CH=8, MAX_POS=250, RD_TIMEOUT=16).
module tb_servo_frame_sched;

    logic        clk;
    logic        reset;
    logic        frame_ready;
    logic [8:0]  frame_len;
    logic        rd_req;
    logic [8:0]  rd_data;
    logic        rd_valid;
    logic        frame_done;
    logic [63:0] ch_pos;
    logic [7:0]  ch_update;
    logic        busy;
    logic [3:0]  err;

    int checks = 0;
    int errors = 0;

    logic [8:0] words [0:7];
    int         r_lat, r_pulses, r_upd_c, r_done_c, r_rdreq, r_busy_low, r_done_seen;
    logic [7:0] r_upd;

    servo_frame_sched #(
        .NUM_CH    (8),
        .MAX_POS   (8'd250),
        .RD_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_ready(frame_ready),
        .frame_len  (frame_len),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .frame_done (frame_done),
        .ch_pos     (ch_pos),
        .ch_update  (ch_update),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Plays the buffer side of one frame; cycle 0 is the IDLE cycle that sees frame_ready.
    task automatic do_frame(input logic [8:0] len, input int withhold_k, input int reset_at);
        int c, k;
        bit pend, fin;
        c = 0; k = 0; pend = 0; fin = 0;
        r_lat = 0; r_upd = '0; r_pulses = 0; r_upd_c = -1; r_done_c = -1;
        r_rdreq = 0; r_busy_low = 0; r_done_seen = 0;
        frame_ready = 1'b1;
        frame_len   = len;
        while (!fin && c < 200) begin
            step();
            c++;
            frame_ready = 1'b0;
            rd_valid    = 1'b0;
            if (c == reset_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                fin = 1;
            end else begin
                if (pend) begin
                    pend = 0;
                    if (k != withhold_k) begin
                        rd_valid = 1'b1;
                        rd_data  = words[k];
                        k++;
                    end
                end
                if (rd_req) begin
                    r_rdreq++;
                    pend = 1;
                end
                if (!busy) r_busy_low++;
                if (|ch_update) begin
                    r_upd |= ch_update;
                    r_pulses++;
                    r_upd_c = c;
                end
                if (frame_done) begin
                    r_done_seen = 1;
                    r_done_c = c;
                    r_lat = c + 1;
                    fin = 1;
                end
            end
        end
        rd_valid = 1'b0;
        if (reset_at < 0) begin
            check("frame_bound", 64'(fin), 64'd1);
            step();
            step();
        end
    endtask

    initial begin
        reset       = 1'b1;
        frame_ready = 1'b0;
        frame_len   = '0;
        rd_data     = '0;
        rd_valid    = 1'b0;
        step();
        step();
        check("rst_rd_req", 64'(rd_req), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_upd", 64'(ch_update), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_pos", ch_pos, 64'd0);
        reset = 1'b0;
        step();

`ifdef SERVO_FRAME_CHECKSUM_EN
        words[0] = 9'd5; words[1] = 9'd6; words[2] = 9'd11;
        do_frame(9'd3, -1, -1);
        check("cs_pos", ch_pos, 64'h0605);
        check("cs_upd", 64'(r_upd), 64'h03);
        check("cs_lat", 64'(r_lat), 64'd12);
        check("cs_rdreq", 64'(r_rdreq), 64'd3);
        check("cs_err", 64'(err), 64'd0);

        words[2] = 9'd12;
        do_frame(9'd3, -1, -1);
        check("csbad_err", 64'(err), 64'b1000);
        check("csbad_pulses", 64'(r_pulses), 64'd0);
        check("csbad_pos", ch_pos, 64'h0605);
        check("csbad_done", 64'(r_done_seen), 64'd1);
`else
        // Nominal three-word frame
        words[0] = 9'd10; words[1] = 9'd20; words[2] = 9'd30;
        do_frame(9'd3, -1, -1);
        check("nom_lat", 64'(r_lat), 64'd12);
        check("nom_upd", 64'(r_upd), 64'h07);
        check("nom_pulses", 64'(r_pulses), 64'd1);
        check("nom_done_after_upd", 64'(r_done_c - r_upd_c), 64'd1);
        check("nom_rdreq", 64'(r_rdreq), 64'd3);
        check("nom_busy", 64'(r_busy_low), 64'd0);
        check("nom_pos", ch_pos, 64'h1E140A);
        check("nom_err", 64'(err), 64'd0);

        // Zero length
        do_frame(9'd0, -1, -1);
        check("len0_rdreq", 64'(r_rdreq), 64'd0);
        check("len0_lat", 64'(r_lat), 64'd2);
        check("len0_err", 64'(err), 64'b0001);
        check("len0_pulses", 64'(r_pulses), 64'd0);
        check("len0_pos", ch_pos, 64'h1E140A);

        // Clamp and reserved word
        words[0] = 9'd255; words[1] = 9'd0;
        do_frame(9'd2, -1, -1);
        check("rng_pos", ch_pos, 64'h1E14FA);
        check("rng_upd", 64'(r_upd), 64'h01);
        check("rng_err", 64'(err), 64'b0011);

        // Timeout on the second read
        words[0] = 9'd40; words[1] = 9'd50; words[2] = 9'd60;
        do_frame(9'd3, 1, -1);
        check("to_err", 64'(err), 64'b0111);
        check("to_lat", 64'(r_lat), 64'd22);
        check("to_pulses", 64'(r_pulses), 64'd0);
        check("to_rdreq", 64'(r_rdreq), 64'd2);
        check("to_pos", ch_pos, 64'h1E14FA);

        // Reset during WAIT of the third word
        words[0] = 9'd1; words[1] = 9'd2; words[2] = 9'd3;
        do_frame(9'd3, -1, 8);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_pos", ch_pos, 64'd0);
        check("mrst_err", 64'(err), 64'd0);
        check("mrst_rd_req", 64'(rd_req), 64'd0);
        check("mrst_upd", 64'(ch_update), 64'd0);
        check("mrst_done", 64'(frame_done), 64'd0);

        // Oversize length
        do_frame(9'd9, -1, -1);
        check("len9_rdreq", 64'(r_rdreq), 64'd0);
        check("len9_done", 64'(r_done_seen), 64'd1);
        check("len9_err", 64'(err), 64'b0001);

        // Normal frame after recovery
        words[0] = 9'd77; words[1] = 9'd88;
        do_frame(9'd2, -1, -1);
        check("post_pos", ch_pos, 64'h584D);
        check("post_upd", 64'(r_upd), 64'h03);
        check("post_lat", 64'(r_lat), 64'd9);
        check("post_err", 64'(err), 64'b0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
